// File: rtl/ddr_word_aligner.sv
// rtl/ddr_word_aligner.sv - DDR bit-pair deserializer with sync-word framing, lock tracking and a valid/ready output register
module ddr_word_aligner #(
    parameter int                WORD_W    = 16,
    parameter logic [WORD_W-1:0] SYNC_WORD = 16'hA5F0,
    parameter int                FRAME_LEN = 4,
    parameter int                MISS_MAX  = 2
) (
    input  logic              C,
    input  logic              R,
    input  logic              CE,
    input  logic              D1,
    input  logic              D2,
    output logic [WORD_W-1:0] DO,
    output logic              DV,
    input  logic              RDY,
    output logic              LOCK,
    output logic              SYNC,
    output logic              OVF
);

    localparam int PW = $clog2(WORD_W / 2);
    localparam int FW = $clog2(FRAME_LEN);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(WORD_W / 2 - 1);
    localparam logic [FW-1:0] SLOT_LAST  = FW'(FRAME_LEN - 1);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(MISS_MAX);

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t            r_state;
    logic [WORD_W-2:0] r_sr;
    logic              r_offset;
    logic [PW-1:0]     r_phase;
    logic [FW-1:0]     r_word;
    logic [MW-1:0]     r_miss;
    logic [WORD_W-1:0] r_do;
    logic              r_dv;
    logic              r_sync;
    logic              r_ovf;

    logic [WORD_W:0]   w_sr_n;
    logic [WORD_W-1:0] w_w0;
    logic [WORD_W-1:0] w_w1;
    logic [WORD_W-1:0] w_word;
    logic [MW-1:0]     w_miss_inc;

    state_t            w_state_n;
    logic              w_offset_n;
    logic [PW-1:0]     w_phase_n;
    logic [FW-1:0]     w_word_n;
    logic [MW-1:0]     w_miss_n;
    logic              w_sync_n;
    logic              w_offer;

    // Only the low WORD_W-1 bits of the widened window survive to the next shift.
    assign w_sr_n     = {r_sr, D1, D2};
    assign w_w0       = w_sr_n[WORD_W-1:0];
    assign w_w1       = w_sr_n[WORD_W:1];
    assign w_word     = r_offset ? w_w1 : w_w0;
    assign w_miss_inc = r_miss + 1'b1;

    always_comb begin
        w_state_n  = r_state;
        w_offset_n = r_offset;
        w_phase_n  = r_phase;
        w_word_n   = r_word;
        w_miss_n   = r_miss;
        w_sync_n   = 1'b0;
        w_offer    = 1'b0;
        if (CE) begin
            case (r_state)
                S_HUNT: begin
                    if (w_w0 == SYNC_WORD || w_w1 == SYNC_WORD) begin
                        w_offset_n = (w_w0 != SYNC_WORD);
                        w_state_n  = S_LOCKED;
                        w_sync_n   = 1'b1;
                        w_phase_n  = '0;
                        w_word_n   = FW'(1);
                        w_miss_n   = '0;
                    end
                end
                S_LOCKED: begin
                    if (r_phase == PHASE_LAST) begin
                        w_phase_n = '0;
                        w_word_n  = (r_word == SLOT_LAST) ? '0 : r_word + 1'b1;
                        if (r_word == '0) begin
                            if (w_word == SYNC_WORD) begin
                                w_sync_n = 1'b1;
                                w_miss_n = '0;
                            end else begin
                                w_miss_n = w_miss_inc;
                                if (w_miss_inc == MISS_LIMIT) begin
                                    w_state_n = S_HUNT;
                                end
                            end
                        end else begin
                            w_offer = 1'b1;
                        end
                    end else begin
                        w_phase_n = r_phase + 1'b1;
                    end
                end
                default: w_state_n = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_state  <= S_HUNT;
            r_sr     <= '0;
            r_offset <= 1'b0;
            r_phase  <= '0;
            r_word   <= '0;
            r_miss   <= '0;
            r_sync   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_offset <= w_offset_n;
            r_phase  <= w_phase_n;
            r_word   <= w_word_n;
            r_miss   <= w_miss_n;
            r_sync   <= w_sync_n;
            if (CE) begin
                r_sr <= w_sr_n[WORD_W-2:0];
            end
        end
    end

    // A word arriving while the previous one is still stalled is lost, not queued.
    always_ff @(posedge C) begin
        if (R) begin
            r_do  <= '0;
            r_dv  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_offer) begin
            if (!r_dv || RDY) begin
                r_do <= w_word;
                r_dv <= 1'b1;
            end else begin
                r_ovf <= 1'b1;
            end
        end else if (r_dv && RDY) begin
            r_dv <= 1'b0;
        end
    end

    assign DO   = r_do;
    assign DV   = r_dv;
    assign LOCK = (r_state == S_LOCKED);
    assign SYNC = r_sync;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_ddr_word_aligner.sv
// tb/tb_ddr_word_aligner.sv - scoreboard bench for ddr_word_aligner against a bit-stream reference model
module tb_ddr_word_aligner;

    localparam int          W  = 16;
    localparam logic [15:0] SW = 16'hA5F0;
    localparam int          FL = 4;
    localparam int          MM = 2;

    logic        C = 1'b0;
    logic        R, CE, D1, D2, RDY;
    logic [15:0] DO;
    logic        DV, LOCK, SYNC, OVF;

    ddr_word_aligner #(.WORD_W(W), .SYNC_WORD(SW), .FRAME_LEN(FL), .MISS_MAX(MM)) dut (
        .C(C), .R(R), .CE(CE), .D1(D1), .D2(D2),
        .DO(DO), .DV(DV), .RDY(RDY), .LOCK(LOCK), .SYNC(SYNC), .OVF(OVF)
    );

    always #5 C = ~C;

    int checks   = 0;
    int failures = 0;

    bit          m_bits[$];
    bit          m_locked, m_off, m_dv, m_sync, m_ovf;
    int          m_pairs, m_slot, m_miss;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    bit          tx_q[$];
    bit          rdy_v  = 1'b1;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] window(input int lag);
        logic [15:0] v = '0;
        int n = m_bits.size();
        for (int i = 0; i < 16; i++) v = {v[14:0], m_bits[n - 16 - lag + i]};
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit ce, input bit d1, input bit d2, input bit rdy);
        bit          offered = 1'b0;
        logic [15:0] w = '0, w0, w1;
        if (r) begin
            m_bits.delete();
            repeat (17) m_bits.push_back(1'b0);
            m_locked = 0; m_off = 0; m_pairs = 0; m_slot = 0; m_miss = 0;
            m_dv = 0; m_sync = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            m_sync = 0;
            if (ce) begin
                m_bits.push_back(d1);
                m_bits.push_back(d2);
                void'(m_bits.pop_front());
                void'(m_bits.pop_front());
                w0 = window(0);
                w1 = window(1);
                if (!m_locked) begin
                    if (w0 == SW || w1 == SW) begin
                        m_off = (w0 != SW); m_locked = 1; m_sync = 1;
                        m_pairs = 0; m_slot = 1; m_miss = 0;
                    end
                end else begin
                    m_pairs++;
                    if (m_pairs == W / 2) begin
                        m_pairs = 0;
                        w = m_off ? w1 : w0;
                        if (m_slot == 0) begin
                            if (w == SW) begin
                                m_sync = 1; m_miss = 0;
                            end else begin
                                m_miss++;
                                if (m_miss == MM) m_locked = 0;
                            end
                        end else begin
                            offered = 1;
                        end
                        m_slot = (m_slot + 1) % FL;
                    end
                end
            end
            if (offered) begin
                if (!m_dv) begin
                    m_dv = 1;
                    exp_q.push_back(w);
                end else if (rdy) begin
                    exp_q.push_back(w);
                end else begin
                    m_ovf = 1;
                end
            end else if (m_dv && rdy) begin
                m_dv = 0;
            end
        end
    endtask

    always @(negedge C) begin
        if (mon_en) begin
            chk("DV",   32'(DV),   32'(m_dv));
            chk("LOCK", 32'(LOCK), 32'(m_locked));
            chk("SYNC", 32'(SYNC), 32'(m_sync));
            chk("OVF",  32'(OVF),  32'(m_ovf));
            if (DV && RDY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word_queue", 32'(exp_q.size()), 32'(1));
                end else begin
                    chk("DO", 32'(DO), 32'(exp_q.pop_front()));
                end
                got_q.push_back(DO);
            end
        end
    end

    task automatic cyc(input bit r, input bit ce, input bit d1, input bit d2);
        R = r; CE = ce; D1 = d1; D2 = d2; RDY = rdy_v;
        @(posedge C);
        #1 model_edge(r, ce, d1, d2, rdy_v);
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) tx_q.push_back(w[i]);
    endtask

    task automatic send_pairs();
        bit b1, b2;
        while (tx_q.size() >= 2) begin
            b1 = tx_q.pop_front();
            b2 = tx_q.pop_front();
            cyc(1'b0, 1'b1, b1, b2);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rdy_v = 1'b1;
        tx_q.delete();
        repeat (2) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        got_q.delete();
    endtask

    task automatic check_got(input string name, input logic [15:0] e[$]);
        chk({name, "_count"}, 32'(got_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got_q.size(); i++)
            chk(name, 32'(got_q[i]), 32'(e[i]));
    endtask

    initial begin
        logic [15:0] e[$];
        int          lead;
        bit          b1, b2;

        R = 1'b1; CE = 1'b0; D1 = 1'b0; D2 = 1'b0; RDY = 1'b1;

        cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        mon_en = 1'b1;
        cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        chk("reset_DO",   32'(DO),   32'h0);
        chk("reset_DV",   32'(DV),   32'h0);
        chk("reset_LOCK", 32'(LOCK), 32'h0);
        chk("reset_OVF",  32'(OVF),  32'h0);
        repeat (8) cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom));

        do_reset();
        push_word(SW); send_pairs();
        chk("acq_LOCK", 32'(LOCK), 32'h1);
        chk("acq_SYNC", 32'(SYNC), 32'h1);
        push_word(16'h1234); push_word(16'hBEEF); push_word(16'h0F0F); push_word(SW);
        send_pairs();
        chk("aligned_sync2", 32'(SYNC), 32'h1);
        idle(2);
        e.delete(); e.push_back(16'h1234); e.push_back(16'hBEEF); e.push_back(16'h0F0F);
        check_got("aligned_words", e);

        do_reset();
        tx_q.push_back(1'b0);
        push_word(SW); push_word(16'h1234); push_word(16'hBEEF); push_word(16'h0F0F); push_word(SW);
        tx_q.push_back(1'b0);
        send_pairs();
        idle(2);
        check_got("offset1_words", e);

        do_reset();
        push_word(SW); send_pairs();
        rdy_v = 1'b0;
        push_word(16'h1234); push_word(16'hBEEF); send_pairs();
        chk("bp_DO",  32'(DO),  32'h1234);
        chk("bp_OVF", 32'(OVF), 32'h1);
        rdy_v = 1'b1;
        push_word(16'h0F0F); send_pairs();
        idle(2);
        chk("bp_OVF_sticky", 32'(OVF), 32'h1);
        e.delete(); e.push_back(16'h1234); e.push_back(16'h0F0F);
        check_got("bp_words", e);

        do_reset();
        push_word(SW); repeat (3) push_word(16'($urandom)); push_word(16'h0000); send_pairs();
        chk("miss1_LOCK", 32'(LOCK), 32'h1);
        chk("miss1_SYNC", 32'(SYNC), 32'h0);
        repeat (3) push_word(16'($urandom)); push_word(SW); send_pairs();
        chk("resync_SYNC", 32'(SYNC), 32'h1);
        repeat (3) push_word(16'($urandom)); push_word(16'h0000); send_pairs();
        chk("miss2a_LOCK", 32'(LOCK), 32'h1);
        repeat (3) push_word(16'($urandom)); push_word(16'h0000); send_pairs();
        chk("lost_LOCK", 32'(LOCK), 32'h0);
        lead = $urandom_range(0, 7);
        repeat (lead) tx_q.push_back(1'($urandom));
        push_word(SW); push_word(16'($urandom)); push_word(16'($urandom));
        if (tx_q.size() % 2 == 1) tx_q.push_back(1'b0);
        send_pairs();
        chk("reacq_LOCK", 32'(LOCK), 32'h1);

        do_reset();
        push_word(SW); send_pairs();
        push_word(16'h1234);
        repeat (4) begin
            b1 = tx_q.pop_front(); b2 = tx_q.pop_front();
            cyc(1'b0, 1'b1, b1, b2);
        end
        idle(3);
        send_pairs();
        chk("ce_DO", 32'(DO), 32'h1234);
        idle(2);
        e.delete(); e.push_back(16'h1234);
        check_got("ce_words", e);

        do_reset();
        rdy_v = 1'b0;
        push_word(SW); push_word(16'h5A5A); send_pairs();
        chk("rst_pre_DV", 32'(DV), 32'h1);
        cyc(1'b1, 1'b1, 1'($urandom), 1'($urandom));
        chk("rst_mid_DO",   32'(DO),   32'h0);
        chk("rst_mid_DV",   32'(DV),   32'h0);
        chk("rst_mid_LOCK", 32'(LOCK), 32'h0);
        chk("rst_mid_SYNC", 32'(SYNC), 32'h0);

        do_reset();
        for (int j = 0; j < 160; j++) begin
            if (j % FL == 0) push_word(($urandom % 8 == 0) ? 16'($urandom) : SW);
            else             push_word(16'($urandom));
            if ($urandom % 20 == 0) tx_q.push_back(1'($urandom));
            while (tx_q.size() >= 2) begin
                rdy_v = ($urandom % 4 != 0);
                if ($urandom % 8 == 0) begin
                    cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
                end else begin
                    b1 = tx_q.pop_front(); b2 = tx_q.pop_front();
                    cyc(1'b0, 1'b1, b1, b2);
                end
            end
        end

        rdy_v = 1'b1;
        idle(4);
        chk("drain_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
